lc3_pipeline_controller: RTL and testbench
==========================================

# lc3_pipeline_controller

Central controller for the LC-3 pipeline. It sequences the fetch, decode, execute, writeback and PC-update stage enables. It stalls the pipeline for multi-cycle data-memory accesses and inserts bubbles behind control-flow instructions. It also generates branch-taken and ALU forwarding (bypass) selects from the decode-stage IR and the execute-stage IR_Exec.

## Interface
Parameters:
- BR_BUBBLES, 3, number of cycles fetch/decode are frozen after a BR/JMP leaves decode

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- complete_data  in  1  data-memory access done; sampled while in MEM
- IR  in  16  decode-stage instruction (same source as decode IR output)
- IR_Exec  in  16  instruction currently held in execute
- NZP  in  3  condition codes from writeback
- enable_fetch  out  1  fetch stage enable (registered)
- enable_updatePC  out  1  PC register update enable (registered)
- enable_decode  out  1  decode stage enable (registered)
- enable_execute  out  1  execute stage enable (registered)
- enable_writeback  out  1  writeback stage enable (registered)
- mem_state  out  2  0 = read, 1 = indirect-address read, 2 = write, 3 = idle (registered)
- br_taken  out  1  redirect PC (combinational)
- bypass_alu_1  out  1  forward execute result to decode source 1 (combinational)
- bypass_alu_2  out  1  forward execute result to decode source 2 (combinational)

## Operation
- Opcode classes (bits [15:12]):
  - ALU: ADD 0001, AND 0101, NOT 1001, LEA 1110
  - CTRL: BR 0000, JMP 1100
  - Loads: LD 0010, LDR 0110, LDI 1010
  - Stores: ST 0011, STR 0111, STI 1011
- FSM states: FILL, RUN, MEM, MEM2, BRSTALL.
- **FILL**
  - A 2-bit counter enables stages in order: fetch+updatePC, then decode, then execute, then writeback, one per cycle.
  - After writeback is enabled, the FSM enters RUN.
- **RUN**
  - If enable_execute=1, IR_Exec is a load/store, and the skip flag is clear: go to MEM.
    - LD/LDR: mem_state=0.
    - ST/STR: mem_state=2.
    - LDI/STI: mem_state=1.
  - Otherwise, if enable_decode=1 and IR is CTRL: go to BRSTALL and load the bubble counter with BR_BUBBLES.
- **MEM**
  - All five enables are 0.
  - Hold until complete_data=1.
  - If mem_state=1: go to MEM2 with mem_state=0 (LDI) or 2 (STI).
  - Otherwise: mem_state=3, restore every enable to 1 (except those frozen by BRSTALL), return to the previous state, and set the one-cycle skip flag.
- **MEM2**
  - Same behaviour as MEM for the second access.
  - Ends with the same restore sequence as MEM.
- **Skip flag**: suppresses memory detection for exactly one RUN/BRSTALL cycle, so the completed instruction is not retriggered.
- **BRSTALL**
  - fetch, updatePC and decode are 0; execute and writeback are 1.
  - The counter decrements each cycle.
  - When the counter reaches 1: re-enable fetch/updatePC/decode on the next edge and return to RUN.
  - A memory op detected in BRSTALL enters MEM. The counter freezes and resumes afterwards.
- **br_taken** = enable_execute & ((IR_Exec is JMP) | (IR_Exec is BR & |(IR_Exec[11:9] & NZP))).
- **bypass_alu_1** = enable_execute & IR_Exec ALU & IR ALU-or-store & (IR_Exec[11:9] == IR[8:6]).
- **bypass_alu_2** = enable_execute & IR_Exec ALU & IR is ADD/AND & IR[5]==0 & (IR_Exec[11:9] == IR[2:0]).
- Bypass outputs are forced to 0 outside RUN.

## Timing
- Reset values: all enables 0, mem_state=3, FSM=FILL, counters 0, skip flag 0. br_taken and bypass outputs are 0 while reset=1.
- Fill sequence, counting edges after reset is first sampled low:
  - edge 1: enable_fetch and enable_updatePC go to 1
  - edge 2: enable_decode goes to 1
  - edge 3: enable_execute goes to 1
  - edge 4: enable_writeback goes to 1 and the FSM enters RUN
- Memory-op detection in RUN: enables fall and mem_state is valid one edge later.
- complete_data is sampled at a rising edge; outputs change at that same edge.
- A single-phase access with complete_data already high is a minimum 1-cycle stall. LDI/STI take a minimum of 2 cycles.
- The BR/JMP bubble lasts exactly BR_BUBBLES cycles, excluding any MEM cycles inserted during it.
- Reset asserted mid-MEM or mid-BRSTALL returns to the reset values at the next edge and restarts FILL.

## Test plan
- Reset release, then NOP ADDs -> enables rise on edges 1/2/3/4 in order; mem_state stays 3.
- IR_Exec=LDR (0x6042), complete_data low for 3 cycles -> enables 0 and mem_state=0 for 4 cycles; enables back to 1 at the edge after complete_data=1; no retrigger.
- IR_Exec=STI (0xB201), complete_data pulsed twice -> mem_state 1 then 2 then 3.
- IR=BR n (0x0802) in decode, then NZP=100 when it reaches execute -> fetch/decode low for 3 cycles; br_taken=1. With NZP=010 -> br_taken=0.
- IR_Exec=ADD R1,R2,R3 (0x1283), IR=ADD R4,R1,R1 (0x1841) -> bypass_alu_1=1 and bypass_alu_2=1. With IR=0x1861 (immediate form) -> bypass_alu_2=0.
- Reset asserted in the 2nd MEM cycle -> all outputs return to reset values at the next edge; FILL restarts.

Source files
------------

// File: rtl/lc3_pipeline_controller.sv
`default_nettype none
// lc3_pipeline_controller: LC-3 stage-enable sequencer with memory stalls, branch bubbles,
// branch-taken and ALU bypass selects.  Revision 1.0
module lc3_pipeline_controller #(
  parameter int BR_BUBBLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2
);

  localparam int CW = (BR_BUBBLES < 2) ? 1 : $clog2(BR_BUBBLES + 1);
  localparam logic [CW-1:0] BUB_INIT = CW'(BR_BUBBLES);
  localparam logic [CW-1:0] BUB_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_FILL    = 3'd0,
    S_RUN     = 3'd1,
    S_MEM     = 3'd2,
    S_MEM2    = 3'd3,
    S_BRSTALL = 3'd4
  } state_t;

  state_t          state_q;
  state_t          ret_q;
  logic [1:0]      fill_q;
  logic [CW-1:0]   bub_q;
  logic            skip_q;
  logic [1:0]      mem_state_q;
  logic [1:0]      phase2_q;
  logic            en_fetch_q, en_pc_q, en_dec_q, en_exe_q, en_wb_q;

  logic [3:0] op_d, op_x;
  logic       x_alu, x_ld, x_st, x_ind, x_mem, x_br, x_jmp;
  logic       d_alu, d_st, d_ctrl, d_addand;
  logic       mem_hit, in_run;
  logic [1:0] single_code;
  logic       unused_bits;

  assign op_d = IR[15:12];
  assign op_x = IR_Exec[15:12];

  assign x_alu = (op_x == 4'b0001) | (op_x == 4'b0101) | (op_x == 4'b1001) | (op_x == 4'b1110);
  assign x_ld  = (op_x == 4'b0010) | (op_x == 4'b0110) | (op_x == 4'b1010);
  assign x_st  = (op_x == 4'b0011) | (op_x == 4'b0111) | (op_x == 4'b1011);
  assign x_ind = (op_x == 4'b1010) | (op_x == 4'b1011);
  assign x_mem = x_ld | x_st;
  assign x_br  = (op_x == 4'b0000);
  assign x_jmp = (op_x == 4'b1100);

  assign d_alu    = (op_d == 4'b0001) | (op_d == 4'b0101) | (op_d == 4'b1001) | (op_d == 4'b1110);
  assign d_st     = (op_d == 4'b0011) | (op_d == 4'b0111) | (op_d == 4'b1011);
  assign d_ctrl   = (op_d == 4'b0000) | (op_d == 4'b1100);
  assign d_addand = (op_d == 4'b0001) | (op_d == 4'b0101);

  assign mem_hit     = en_exe_q & x_mem & ~skip_q;
  assign single_code = x_st ? 2'd2 : 2'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FILL;
      ret_q       <= S_RUN;
      fill_q      <= 2'd0;
      bub_q       <= '0;
      skip_q      <= 1'b0;
      mem_state_q <= 2'd3;
      phase2_q    <= 2'd0;
      en_fetch_q  <= 1'b0;
      en_pc_q     <= 1'b0;
      en_dec_q    <= 1'b0;
      en_exe_q    <= 1'b0;
      en_wb_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          fill_q <= fill_q + 2'd1;
          case (fill_q)
            2'd0: begin
              en_fetch_q <= 1'b1;
              en_pc_q    <= 1'b1;
            end
            2'd1: en_dec_q <= 1'b1;
            2'd2: en_exe_q <= 1'b1;
            default: begin
              en_wb_q <= 1'b1;
              state_q <= S_RUN;
            end
          endcase
        end
        S_RUN, S_BRSTALL: begin
          skip_q <= 1'b0;
          if (mem_hit) begin
            en_fetch_q  <= 1'b0;
            en_pc_q     <= 1'b0;
            en_dec_q    <= 1'b0;
            en_exe_q    <= 1'b0;
            en_wb_q     <= 1'b0;
            mem_state_q <= x_ind ? 2'd1 : single_code;
            phase2_q    <= single_code;
            state_q     <= S_MEM;
            // The detecting bubble cycle still counts; a finished bubble resumes straight to RUN.
            if (state_q == S_BRSTALL) begin
              bub_q <= bub_q - BUB_ONE;
              ret_q <= (bub_q == BUB_ONE) ? S_RUN : S_BRSTALL;
            end else begin
              ret_q <= S_RUN;
            end
          end else if (state_q == S_RUN) begin
            if (en_dec_q && d_ctrl) begin
              en_fetch_q <= 1'b0;
              en_pc_q    <= 1'b0;
              en_dec_q   <= 1'b0;
              bub_q      <= BUB_INIT;
              state_q    <= S_BRSTALL;
            end
          end else if (bub_q == BUB_ONE) begin
            en_fetch_q <= 1'b1;
            en_pc_q    <= 1'b1;
            en_dec_q   <= 1'b1;
            state_q    <= S_RUN;
          end else begin
            bub_q <= bub_q - BUB_ONE;
          end
        end
        S_MEM, S_MEM2: begin
          if (complete_data) begin
            if ((state_q == S_MEM) && (mem_state_q == 2'd1)) begin
              mem_state_q <= phase2_q;
              state_q     <= S_MEM2;
            end else begin
              mem_state_q <= 2'd3;
              skip_q      <= 1'b1;
              state_q     <= ret_q;
              en_fetch_q  <= (ret_q == S_RUN);
              en_pc_q     <= (ret_q == S_RUN);
              en_dec_q    <= (ret_q == S_RUN);
              en_exe_q    <= 1'b1;
              en_wb_q     <= 1'b1;
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign enable_fetch     = en_fetch_q;
  assign enable_updatePC  = en_pc_q;
  assign enable_decode    = en_dec_q;
  assign enable_execute   = en_exe_q;
  assign enable_writeback = en_wb_q;
  assign mem_state        = mem_state_q;

  assign in_run   = ~reset & (state_q == S_RUN);
  assign br_taken = ~reset & en_exe_q & (x_jmp | (x_br & (|(IR_Exec[11:9] & NZP))));

  assign bypass_alu_1 = in_run & en_exe_q & x_alu & (d_alu | d_st) &
                        (IR_Exec[11:9] == IR[8:6]);
  assign bypass_alu_2 = in_run & en_exe_q & x_alu & d_addand & ~IR[5] &
                        (IR_Exec[11:9] == IR[2:0]);

  assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

endmodule
`default_nettype wire

// File: tb/tb_lc3_pipeline_controller.sv
`default_nettype none
// tb_lc3_pipeline_controller: directed vector table plus randomized run against a queue-based model.
module tb_lc3_pipeline_controller;

  localparam int BR_BUBBLES = 3;
  localparam logic [15:0] NIR = 16'h1000;  // ADD R0,R0,R0
  localparam logic [15:0] NX  = 16'h1E00;  // ADD R7,R0,R0 (no register overlap with NIR)

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        complete_data = 1'b0;
  logic [15:0] IR = NIR;
  logic [15:0] IR_Exec = NX;
  logic [2:0]  NZP = 3'b000;
  logic        enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback;
  logic [1:0]  mem_state;
  logic        br_taken, bypass_alu_1, bypass_alu_2;

  lc3_pipeline_controller #(.BR_BUBBLES(BR_BUBBLES)) dut (
    .clock(clock), .reset(reset), .complete_data(complete_data),
    .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP),
    .enable_fetch(enable_fetch), .enable_updatePC(enable_updatePC),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .mem_state(mem_state),
    .br_taken(br_taken), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  wire [4:0] act_en  = {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback};
  wire [2:0] act_cmb = {br_taken, bypass_alu_1, bypass_alu_2};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model: fill edges, access queue, bubbles left ----------------
  int m_fill = 0;
  int m_left = 0;
  bit m_skip = 0;
  int m_memq[$];

  function automatic bit is_alu(input logic [3:0] op);
    return op inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};
  endfunction
  function automatic bit is_store(input logic [3:0] op);
    return op inside {4'b0011, 4'b0111, 4'b1011};
  endfunction
  function automatic bit is_mem(input logic [3:0] op);
    return is_store(op) || (op inside {4'b0010, 4'b0110, 4'b1010});
  endfunction

  function automatic logic [4:0] m_en();
    if (m_fill < 4) return {m_fill >= 1, m_fill >= 1, m_fill >= 2, m_fill >= 3, 1'b0};
    if (m_memq.size() != 0) return 5'b00000;
    return (m_left == 0) ? 5'b11111 : 5'b00011;
  endfunction

  function automatic logic [1:0] m_ms();
    return (m_memq.size() != 0) ? 2'(m_memq[0]) : 2'd3;
  endfunction

  function automatic logic [2:0] m_cmb();
    logic [4:0] en;
    logic exe, run, br, b1, b2;
    en  = m_en();
    exe = en[1] && !reset;
    run = !reset && m_fill == 4 && m_memq.size() == 0 && m_left == 0;
    br  = exe && (IR_Exec[15:12] == 4'b1100 ||
                  (IR_Exec[15:12] == 4'b0000 && (IR_Exec[11:9] & NZP) != 3'b000));
    b1  = run && is_alu(IR_Exec[15:12]) && (is_alu(IR[15:12]) || is_store(IR[15:12])) &&
          IR_Exec[11:9] == IR[8:6];
    b2  = run && is_alu(IR_Exec[15:12]) && IR[15:12] inside {4'b0001, 4'b0101} && !IR[5] &&
          IR_Exec[11:9] == IR[2:0];
    return {br, b1, b2};
  endfunction

  task automatic model_edge();
    bit was_skip;
    if (reset) begin
      m_fill = 0; m_left = 0; m_skip = 0; m_memq.delete();
    end else if (m_fill < 4) begin
      m_fill++;
    end else if (m_memq.size() != 0) begin
      if (complete_data) begin
        m_memq.delete(0);
        if (m_memq.size() == 0) m_skip = 1;
      end
    end else begin
      was_skip = m_skip;
      m_skip = 0;
      if (!was_skip && is_mem(IR_Exec[15:12])) begin
        case (IR_Exec[15:12])
          4'b0010, 4'b0110: m_memq.push_back(0);
          4'b0011, 4'b0111: m_memq.push_back(2);
          4'b1010: begin m_memq.push_back(1); m_memq.push_back(0); end
          default: begin m_memq.push_back(1); m_memq.push_back(2); end
        endcase
        if (m_left > 0) m_left--;
      end else if (m_left > 0) begin
        m_left--;
      end else if (IR[15:12] inside {4'b0000, 4'b1100}) begin
        m_left = BR_BUBBLES;
      end
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic [15:0] ir,
                       input logic [15:0] irx, input logic [2:0] nzp);
    @(negedge clock);
    reset = r; complete_data = c; IR = ir; IR_Exec = irx; NZP = nzp;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clock);
    model_edge();
    cyc++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        cd;
    logic [15:0] ir;
    logic [15:0] irx;
    logic [2:0]  nzp;
    logic [4:0]  en;
    logic [1:0]  ms;
    logic [2:0]  cmb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic cd, input logic [15:0] ir,
                             input logic [15:0] irx, input logic [2:0] nzp,
                             input logic [4:0] en, input logic [1:0] ms, input logic [2:0] cmb);
    vec_t t;
    t.rst = rst; t.cd = cd; t.ir = ir; t.irx = irx; t.nzp = nzp;
    t.en = en; t.ms = ms; t.cmb = cmb;
    return t;
  endfunction

  initial begin
    logic        r, c;
    logic [15:0] ir, irx;
    logic [2:0]  nzp;

    // reset, fill edges 1..4
    tbl.push_back(v(1, 0, NIR, NX, 3'b000, 5'b00000, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX, 3'b000, 5'b00000, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX, 3'b000, 5'b11000, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX, 3'b000, 5'b11100, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX, 3'b000, 5'b11110, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX, 3'b000, 5'b11111, 2'd3, 3'b000));
    // bypass: register form then immediate form
    tbl.push_back(v(0, 0, 16'h1841, 16'h1283, 3'b000, 5'b11111, 2'd3, 3'b011));
    tbl.push_back(v(0, 0, 16'h1861, 16'h1283, 3'b000, 5'b11111, 2'd3, 3'b010));
    // LDR with complete_data low for 3 cycles
    tbl.push_back(v(0, 0, NIR, 16'h6042, 3'b000, 5'b11111, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, 16'h6042, 3'b000, 5'b00000, 2'd0, 3'b000));
    tbl.push_back(v(0, 0, NIR, 16'h6042, 3'b000, 5'b00000, 2'd0, 3'b000));
    tbl.push_back(v(0, 0, NIR, 16'h6042, 3'b000, 5'b00000, 2'd0, 3'b000));
    tbl.push_back(v(0, 1, NIR, 16'h6042, 3'b000, 5'b00000, 2'd0, 3'b000));
    tbl.push_back(v(0, 0, NIR, 16'h6042, 3'b000, 5'b11111, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX,       3'b000, 5'b11111, 2'd3, 3'b000));
    // STI with complete_data already high: 1 -> 2 -> 3
    tbl.push_back(v(0, 1, NIR, 16'hB201, 3'b000, 5'b11111, 2'd3, 3'b000));
    tbl.push_back(v(0, 1, NIR, 16'hB201, 3'b000, 5'b00000, 2'd1, 3'b000));
    tbl.push_back(v(0, 1, NIR, 16'hB201, 3'b000, 5'b00000, 2'd2, 3'b000));
    tbl.push_back(v(0, 0, NIR, 16'hB201, 3'b000, 5'b11111, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX,       3'b000, 5'b11111, 2'd3, 3'b000));
    // BR n: three bubbles, taken with N, not taken with Z, no bypass in the bubble
    tbl.push_back(v(0, 0, 16'h0802, NX,       3'b100, 5'b11111, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR,      16'h0802, 3'b100, 5'b00011, 2'd3, 3'b100));
    tbl.push_back(v(0, 0, NIR,      16'h0802, 3'b010, 5'b00011, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, 16'h1841, 16'h1283, 3'b000, 5'b00011, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR,      NX,       3'b000, 5'b11111, 2'd3, 3'b000));
    // reset in the second MEM cycle
    tbl.push_back(v(0, 0, NIR, 16'h6042, 3'b000, 5'b11111, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, 16'h6042, 3'b000, 5'b00000, 2'd0, 3'b000));
    tbl.push_back(v(1, 0, NIR, 16'h6042, 3'b000, 5'b00000, 2'd0, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX,       3'b000, 5'b00000, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX,       3'b000, 5'b11000, 2'd3, 3'b000));
    tbl.push_back(v(0, 0, NIR, NX,       3'b000, 5'b11100, 2'd3, 3'b000));

    edge_step();
    edge_step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].cd, tbl[i].ir, tbl[i].irx, tbl[i].nzp);
      chk($sformatf("vec%0d_enables", i), {3'b0, act_en},    {3'b0, tbl[i].en});
      chk($sformatf("vec%0d_mem_state", i), {6'b0, mem_state}, {6'b0, tbl[i].ms});
      chk($sformatf("vec%0d_br_bypass", i), {5'b0, act_cmb},   {5'b0, tbl[i].cmb});
      edge_step();
    end

    // randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      r   = (k == 0) || ($urandom_range(0, 299) == 0);
      c   = ($urandom_range(0, 2) != 0);
      ir  = 16'($urandom());
      irx = 16'($urandom());
      nzp = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) ir[8:6] = irx[11:9];
      if ($urandom_range(0, 1) == 1) ir[2:0] = irx[11:9];
      drive(r, c, ir, irx, nzp);
      chk("rand_enables",   {3'b0, act_en},    {3'b0, m_en()});
      chk("rand_mem_state", {6'b0, mem_state}, {6'b0, m_ms()});
      chk("rand_br_bypass", {5'b0, act_cmb},   {5'b0, m_cmb()});
      edge_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
